event_deserializer: RTL
=======================

Name: event_deserializer

Overview:
- Receive side of the byte-stream event link produced by the team's serializer.
- Parses length-prefixed frames from an 8-bit valid-qualified stream and buffers each event's samples.
- Replays a complete event as one contiguous burst with first/last markers; drops malformed or stalled frames.
- Sits between the link receiver and downstream event processing.

Parameters:
- MAX_SAMPLES, 8: maximum samples per frame; buffer depth.
- TIMEOUT, 64: idle cycles allowed mid-frame before the frame is aborted.
- CNT_W, 16: width of the good-frame counter.

Ports:
- clk, input, 1: single clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- din, input, 8: incoming stream byte.
- din_valid, input, 1: din is valid this cycle. There is no backpressure.
- dout, output, 8: replayed sample.
- dout_valid, output, 1: dout is valid.
- dout_first, output, 1: first sample of an event.
- dout_last, output, 1: last sample of an event.
- frame_err, output, 1: 1-cycle pulse when a frame is discarded (bad length, timeout, checksum).
- overflow, output, 1: 1-cycle pulse when an input byte is dropped because the block is busy replaying.
- frame_cnt, output, CNT_W: count of good frames delivered.

Behaviour:
- Frame format: length byte N (1..MAX_SAMPLES), then N data bytes. Bytes need not be contiguous; gaps with din_valid=0 are allowed.
- Reset values: dout=0, dout_valid=0, dout_first=0, dout_last=0, frame_err=0, overflow=0, frame_cnt=0. State=IDLE; index and timeout counters cleared.
- Reset mid-operation discards any partial frame or remaining replay. It takes effect at the next edge.
- All outputs are registered.
- IDLE:
  - din_valid with 1<=din<=MAX_SAMPLES: latch len=din, idx=0, go to DATA.
  - din_valid with din=0 or din>MAX_SAMPLES: frame_err pulses the next cycle; stay in IDLE.
- DATA:
  - Each valid byte is written to buf[idx] and idx increments.
  - When the byte with idx==len-1 is written, go to OUT, or to CHK if the optional feature is compiled in.
  - The gap counter clears on every valid byte and increments on every invalid cycle.
  - When the gap counter reaches TIMEOUT: frame_err pulses, the partial frame is discarded, go to IDLE.
- OUT:
  - Replays buf[0..len-1], one byte per cycle, with dout_valid continuously high.
  - dout_first is high with buf[0]; dout_last is high with buf[len-1]. For len=1, both are high in the same cycle.
  - First dout_valid is registered on the edge after the final data byte is sampled (1-cycle latency).
  - frame_cnt increments with the dout_last beat and wraps modulo 2^CNT_W.
  - Returns to IDLE after the last beat, so a length byte arriving the cycle after dout_last is accepted.
- Any din_valid during OUT is dropped and overflow pulses; the replay is not disturbed.
- frame_err and overflow can never assert in the same cycle, because they come from different states.
- The buffer is not cleared between frames; stale contents are never output.

Optional Feature:
- Macro: EVENT_DESER_CHECKSUM_EN.
- With it defined:
  - The frame carries one extra trailing byte equal to the XOR of the length byte and all data bytes.
  - The CHK state waits for that byte, with the same timeout rule as DATA.
  - Match: go to OUT.
  - Mismatch: frame_err pulses, the frame is discarded, frame_cnt is unchanged, go to IDLE.
  - Replay latency is measured from the checksum byte.
- Without it: there is no CHK state, no running XOR register, and no trailing byte.

Test Plan:
- Back-to-back stream 04,A1,B2,C3,D4 -> dout A1,B2,C3,D4 on 4 consecutive cycles. first with A1, last with D4. frame_cnt=1. No error pulses.
- Stream 02,E5,(3 idle cycles),F6 -> dout E5,F6 with first/last. frame_cnt increments. Gaps are tolerated.
- Length 00, then length 09 (MAX_SAMPLES=8) -> two frame_err pulses, no dout_valid. A following 01,7E frame outputs 7E with first and last both high.
- 03,11,22 then TIMEOUT idle cycles -> one frame_err. A following 01,33 outputs only 33.
- 02,AA,BB then a byte 55 during the replay -> overflow pulses once. Output is AA,BB intact. 55 is not treated as a length byte.
- rst asserted after 03,11 -> all outputs return to 0 the next cycle. A following 01,44 outputs 44, frame_cnt=1.
- With EVENT_DESER_CHECKSUM_EN: 02,E5,F6,11 (02^E5^F6=11) -> replay E5,F6. 02,E5,F6,12 -> frame_err, no replay.

Source files
------------

// File: rtl/event_deserializer.sv
// Receive-side event deserializer: parses length-prefixed frames from a byte stream,
// buffers the samples and replays each event as one burst. Define EVENT_DESER_CHECKSUM_EN for trailing XOR check.
module event_deserializer #(
  parameter int MAX_SAMPLES = 8,
  parameter int TIMEOUT     = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic [7:0]       dout,
  output logic             dout_valid,
  output logic             dout_first,
  output logic             dout_last,
  output logic             frame_err,
  output logic             overflow,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int PTR_W = (MAX_SAMPLES > 1) ? $clog2(MAX_SAMPLES) : 1;
  localparam int GAP_W = $clog2(TIMEOUT + 1);

`ifdef EVENT_DESER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, DATA, OUT, CHK} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, OUT} state_t;
`endif

  state_t           state;
  logic [PTR_W-1:0] idx;
  logic [PTR_W-1:0] rd_idx;
  logic [PTR_W-1:0] last_idx;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       sample_buf [MAX_SAMPLES];
`ifdef EVENT_DESER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  // NOTE: the sample buffer has no reset; replay only ever reads indices written by the current frame.
  always_ff @(posedge clk) begin
    if (state == DATA && din_valid)
      sample_buf[idx] <= din;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      rd_idx     <= '0;
      last_idx   <= '0;
      gap_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_first <= 1'b0;
      dout_last  <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      frame_cnt  <= '0;
`ifdef EVENT_DESER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      // Strobes default low; each state raises only the ones it owns.
      dout_valid <= 1'b0;
      dout_first <= 1'b0;
      dout_last  <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;

      case (state)
        IDLE: begin
          if (din_valid) begin
            if (din != 8'd0 && din <= 8'(MAX_SAMPLES)) begin
              last_idx <= PTR_W'(din - 8'd1);
              idx      <= '0;
              gap_cnt  <= '0;
`ifdef EVENT_DESER_CHECKSUM_EN
              csum     <= din;
`endif
              state    <= DATA;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end

        DATA: begin
          if (din_valid) begin
            gap_cnt <= '0;
`ifdef EVENT_DESER_CHECKSUM_EN
            csum    <= csum ^ din;
`endif
            if (idx == last_idx) begin
              rd_idx <= '0;
`ifdef EVENT_DESER_CHECKSUM_EN
              state  <= CHK;
`else
              state  <= OUT;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end else if (gap_cnt == GAP_W'(TIMEOUT - 1)) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

`ifdef EVENT_DESER_CHECKSUM_EN
        CHK: begin
          if (din_valid) begin
            if (din == csum) begin
              state <= OUT;
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end else if (gap_cnt == GAP_W'(TIMEOUT - 1)) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
`endif

        OUT: begin
          dout       <= sample_buf[rd_idx];
          dout_valid <= 1'b1;
          dout_first <= (rd_idx == '0);
          dout_last  <= (rd_idx == last_idx);
          overflow   <= din_valid;
          // Leaving on the last beat lets a length byte in the following cycle be accepted.
          if (rd_idx == last_idx) begin
            frame_cnt <= frame_cnt + 1'b1;
            state     <= IDLE;
          end else begin
            rd_idx <= rd_idx + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
